// File: rtl/gp_dbg_pkg.sv
// Shared types for the deadlock reporter: FSM states, defaults
// and the report record layout.
package gp_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        REPORT,
        HOLD
    } dl_state_e;

    localparam int NUM_MON_DEF        = 4;
    localparam int ID_W_DEF           = 2;
    localparam int CONFIRM_CYCLES_DEF = 16;
    localparam int TS_W_DEF           = 32;

    typedef struct packed {
        logic [NUM_MON_DEF-1:0] mask;
        logic [ID_W_DEF-1:0]    mon_id;
        logic [TS_W_DEF-1:0]    timestamp;
    } rpt_rec_t;

endpackage

// File: rtl/gp_deadlock_reporter_if.sv
// Report record channel: valid/ready plus the latched mask,
// lowest monitor index and confirmation timestamp.
interface gp_deadlock_reporter_if #(
    parameter int NUM_MON = 4,
    parameter int ID_W    = 2,
    parameter int TS_W    = 32
);
    logic               rpt_valid;
    logic               rpt_ready;
    logic [NUM_MON-1:0] rpt_mask;
    logic [ID_W-1:0]    rpt_mon_id;
    logic [TS_W-1:0]    rpt_timestamp;

    modport master (
        output rpt_valid,
        output rpt_mask,
        output rpt_mon_id,
        output rpt_timestamp,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_mask,
        input  rpt_mon_id,
        input  rpt_timestamp,
        output rpt_ready
    );
endinterface

// File: rtl/gp_lsb_index.sv
// Priority encoder: index of the lowest set bit, plus an any-set flag.
module gp_lsb_index
    import gp_dbg_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_MON-1:0] vec,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (vec[i]) idx = ID_W'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/gp_deadlock_reporter.sv
// Confirms persistent monitor block masks and issues one report per episode.
// Define GP_DEADLOCK_AUTO_REARM_EN to let HOLD rearm after 2 idle cycles.
module gp_deadlock_reporter
    import gp_dbg_pkg::*;
#(
    parameter int NUM_MON        = 4,
    parameter int CONFIRM_CYCLES = CONFIRM_CYCLES_DEF,
    parameter int TS_W           = TS_W_DEF,
    parameter int ID_W           = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_MON-1:0]     mon_block,
    input  logic                   clear,
    gp_deadlock_reporter_if.master rpt,
    output logic                   deadlock
);

    localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dl_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MON-1:0] s_mask_q, s_mask_d;
    logic [NUM_MON-1:0] cand_q, cand_d;
    logic [ID_W-1:0]    cand_id_q, cand_id_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic               valid_q, valid_d;
    logic               dead_q, dead_d;
    logic [NUM_MON-1:0] mask_q, mask_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [TS_W-1:0]    tsr_q, tsr_d;
`ifdef GP_DEADLOCK_AUTO_REARM_EN
    logic               zero_q, zero_d;
`endif

    logic [ID_W-1:0]    s_id;
    logic               s_any;

    // Candidate index is encoded whenever the candidate is loaded.
    gp_lsb_index #(
        .NUM_MON (NUM_MON),
        .ID_W    (ID_W)
    ) u_lsb (
        .vec (s_mask_q),
        .idx (s_id),
        .any (s_any)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_mask_d  = mon_block;
        cand_d    = cand_q;
        cand_id_d = cand_id_q;
        ts_d      = ts_q + TS_W'(1);
        valid_d   = valid_q;
        dead_d    = dead_q;
        mask_d    = mask_q;
        id_d      = id_q;
        tsr_d     = tsr_q;
`ifdef GP_DEADLOCK_AUTO_REARM_EN
        zero_d    = zero_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (s_any) begin
                    cnt_d     = CNT_W'(1);
                    cand_d    = s_mask_q;
                    cand_id_d = s_id;
                    state_d   = CONFIRM;
                end
            end
            CONFIRM: begin
                if (cnt_q == CNT_HIT) begin
                    mask_d  = cand_q;
                    id_d    = cand_id_q;
                    tsr_d   = ts_q;
                    valid_d = 1'b1;
                    dead_d  = 1'b1;
                    state_d = REPORT;
                end else if (!s_any) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (s_mask_q == cand_q) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d     = CNT_W'(1);
                    cand_d    = s_mask_q;
                    cand_id_d = s_id;
                end
            end
            REPORT: begin
                if (rpt.rpt_ready) begin
                    valid_d = 1'b0;
                    state_d = HOLD;
`ifdef GP_DEADLOCK_AUTO_REARM_EN
                    zero_d  = 1'b0;
`endif
                end
            end
            HOLD: begin
`ifdef GP_DEADLOCK_AUTO_REARM_EN
                if (s_any) begin
                    zero_d = 1'b0;
                end else if (zero_q) begin
                    zero_d  = 1'b0;
                    dead_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    zero_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        // Software clear wins over acceptance and confirmation.
        if (clear) begin
            state_d = IDLE;
            dead_d  = 1'b0;
            valid_d = 1'b0;
            cnt_d   = '0;
`ifdef GP_DEADLOCK_AUTO_REARM_EN
            zero_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s_mask_q  <= '0;
            cand_q    <= '0;
            cand_id_q <= '0;
            ts_q      <= '0;
            valid_q   <= 1'b0;
            dead_q    <= 1'b0;
            mask_q    <= '0;
            id_q      <= '0;
            tsr_q     <= '0;
`ifdef GP_DEADLOCK_AUTO_REARM_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_mask_q  <= s_mask_d;
            cand_q    <= cand_d;
            cand_id_q <= cand_id_d;
            ts_q      <= ts_d;
            valid_q   <= valid_d;
            dead_q    <= dead_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
            tsr_q     <= tsr_d;
`ifdef GP_DEADLOCK_AUTO_REARM_EN
            zero_q    <= zero_d;
`endif
        end
    end

    assign rpt.rpt_valid     = valid_q;
    assign rpt.rpt_mask      = mask_q;
    assign rpt.rpt_mon_id    = id_q;
    assign rpt.rpt_timestamp = tsr_q;
    assign deadlock          = dead_q;

endmodule

// File: tb/tb_gp_deadlock_reporter.sv
// Directed bench for gp_deadlock_reporter (default build or
// GP_DEADLOCK_AUTO_REARM_EN).
module tb_gp_deadlock_reporter;
    import gp_dbg_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  mon_block = '0;
    logic        deadlock;
    int unsigned cyc;
    int          n_checks = 0;
    int          n_errors = 0;

    gp_deadlock_reporter_if #(.NUM_MON(4), .ID_W(2), .TS_W(32)) if_rpt ();

    gp_deadlock_reporter #(
        .NUM_MON        (4),
        .CONFIRM_CYCLES (16),
        .TS_W           (32),
        .ID_W           (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mon_block (mon_block),
        .clear     (clear),
        .rpt       (if_rpt.master),
        .deadlock  (deadlock)
    );

    always #5 clock = ~clock;

    // Reference cycle count; equals the DUT timestamp in any cycle.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input int lim, output int n, output bit got);
        n = 0;
        got = 1'b0;
        while (n < lim && !got) begin
            step();
            n++;
            if (if_rpt.rpt_valid) got = 1'b1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    rpt_rec_t    rec;
    int          n, first, pulses;
    bit          got, seen, stable;
    int unsigned k;

    initial begin
        if_rpt.rpt_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", 64'(if_rpt.rpt_valid), 0);
        chk("rst_dead", 64'(deadlock), 0);
        chk("rst_mask", 64'(if_rpt.rpt_mask), 0);
        chk("rst_id", 64'(if_rpt.rpt_mon_id), 0);
        chk("rst_ts", 64'(if_rpt.rpt_timestamp), 0);
        reset_n = 1'b1;
        step();

        // Persistent single monitor
        if_rpt.rpt_ready = 1'b1;
        k = cyc;
        mon_block = 4'b0100;
        first = 0;
        pulses = 0;
        rec = '0;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (if_rpt.rpt_valid) begin
                pulses++;
                if (first == 0) begin
                    first = i;
                    rec = {if_rpt.rpt_mask, if_rpt.rpt_mon_id,
                           if_rpt.rpt_timestamp};
                end
            end
        end
        chk("t1_latency", 64'(first), 18);
        chk("t1_pulses", 64'(pulses), 1);
        chk("t1_mask", 64'(rec.mask), 64'(4'b0100));
        chk("t1_id", 64'(rec.mon_id), 2);
        chk("t1_ts", 64'(rec.timestamp), 64'(k + 17));
        chk("t1_dead", 64'(deadlock), 1);

        // Rearm after the mask drains
        mon_block = 4'b0000;
        repeat (3) step();
`ifdef GP_DEADLOCK_AUTO_REARM_EN
        chk("rearm_dead_fall", 64'(deadlock), 0);
`else
        chk("hold_dead_kept", 64'(deadlock), 1);
`endif
        mon_block = 4'b1000;
        wait_valid(30, n, got);
`ifdef GP_DEADLOCK_AUTO_REARM_EN
        chk("rearm_got", 64'(got), 1);
        chk("rearm_lat", 64'(n), 18);
        chk("rearm_id", 64'(if_rpt.rpt_mon_id), 3);
`else
        chk("hold_no_rpt", 64'(got), 0);
        chk("hold_dead", 64'(deadlock), 1);
`endif
        mon_block = 4'b0000;
        pulse_clear();
        chk("clr_dead", 64'(deadlock), 0);
        chk("clr_valid", 64'(if_rpt.rpt_valid), 0);

        // Glitch filter
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            mon_block = (i < 10 || (i >= 11 && i < 21)) ? 4'b0001 : 4'b0000;
            step();
            if (if_rpt.rpt_valid) seen = 1'b1;
        end
        chk("glitch_valid", 64'(seen), 0);
        chk("glitch_dead", 64'(deadlock), 0);

        // Mask change restarts the window
        mon_block = 4'b0011;
        repeat (10) step();
        k = cyc;
        mon_block = 4'b0010;
        wait_valid(40, n, got);
        chk("chg_got", 64'(got), 1);
        chk("chg_lat", 64'(n), 18);
        chk("chg_mask", 64'(if_rpt.rpt_mask), 64'(4'b0010));
        chk("chg_id", 64'(if_rpt.rpt_mon_id), 1);
        chk("chg_ts", 64'(if_rpt.rpt_timestamp), 64'(k + 17));
        mon_block = 4'b0000;
        pulse_clear();

        // Backpressure
        if_rpt.rpt_ready = 1'b0;
        mon_block = 4'b0001;
        wait_valid(40, n, got);
        chk("bp_got", 64'(got), 1);
        rec = {if_rpt.rpt_mask, if_rpt.rpt_mon_id, if_rpt.rpt_timestamp};
        stable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            mon_block = (i % 2 == 1) ? 4'b0110 : 4'b1001;
            step();
            if (!if_rpt.rpt_valid ||
                if_rpt.rpt_mask != rec.mask ||
                if_rpt.rpt_mon_id != rec.mon_id ||
                if_rpt.rpt_timestamp != rec.timestamp)
                stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 1);
        chk("bp_mask", 64'(rec.mask), 64'(4'b0001));
        chk("bp_id", 64'(rec.mon_id), 0);
        if_rpt.rpt_ready = 1'b1;
        step();
        if_rpt.rpt_ready = 1'b0;
        chk("bp_drop", 64'(if_rpt.rpt_valid), 0);
        chk("bp_hold_mask", 64'(if_rpt.rpt_mask), 64'(rec.mask));
        chk("bp_dead", 64'(deadlock), 1);
        mon_block = 4'b0000;
        pulse_clear();

        // Clear beats acceptance
        mon_block = 4'b0010;
        wait_valid(40, n, got);
        chk("cp_got", 64'(got), 1);
        mon_block = 4'b0000;
        if_rpt.rpt_ready = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        if_rpt.rpt_ready = 1'b0;
        chk("cp_valid", 64'(if_rpt.rpt_valid), 0);
        chk("cp_dead", 64'(deadlock), 0);
        // Back in IDLE: a fresh episode must report again
        if_rpt.rpt_ready = 1'b1;
        mon_block = 4'b0100;
        wait_valid(40, n, got);
        chk("cp_idle_got", 64'(got), 1);
        chk("cp_idle_id", 64'(if_rpt.rpt_mon_id), 2);
        step();

        // Asynchronous reset while in HOLD
        #2 reset_n = 1'b0;
        #1;
        chk("ar_dead", 64'(deadlock), 0);
        chk("ar_mask", 64'(if_rpt.rpt_mask), 0);
        chk("ar_id", 64'(if_rpt.rpt_mon_id), 0);
        chk("ar_ts", 64'(if_rpt.rpt_timestamp), 0);
        step();
        reset_n = 1'b1;

        // Asynchronous reset mid-confirm after a retained report
        mon_block = 4'b1000;
        wait_valid(40, n, got);
        chk("ar2_got", 64'(got), 1);
        mon_block = 4'b0000;
        pulse_clear();
        mon_block = 4'b0001;
        repeat (6) step();
        #2 reset_n = 1'b0;
        #1;
        chk("ar2_mask", 64'(if_rpt.rpt_mask), 0);
        chk("ar2_id", 64'(if_rpt.rpt_mon_id), 0);
        chk("ar2_valid", 64'(if_rpt.rpt_valid), 0);
        chk("ar2_dead", 64'(deadlock), 0);
        mon_block = 4'b0000;
        step();
        reset_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
